// File: rtl/async_fifo_core.sv
// rtl/async_fifo_core.sv - single-clock FWFT FIFO, 8 x 16-bit, async active-high reset
module async_fifo_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // Wrap bit distinguishes full from empty when the addresses coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_async_fifo_core.sv
// tb/tb_async_fifo_core.sv - directed and random checks of async_fifo_core against a queue model
module tb_async_fifo_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        full;
  logic        empty;

  int n_assert = 0;
  int n_fail = 0;
  logic [15:0] model_q [$];

  async_fifo_core #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".empty"}, {15'b0, empty}, {15'b0, model_q.size() == 0});
    check({tag, ".full"}, {15'b0, full}, {15'b0, model_q.size() == 8});
    check({tag, ".rd_data"}, rd_data, (model_q.size() == 0) ? 16'h0 : model_q[0]);
  endtask

  // One clock of stimulus; the model uses occupancy from before the edge.
  task automatic step(input logic we, input logic [15:0] wd, input logic re);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en = we; wr_data = wd; rd_en = re;
    was_full = (model_q.size() == 8);
    was_empty = (model_q.size() == 0);
    @(posedge clk);
    if (re && !was_empty) void'(model_q.pop_front());
    if (we && !was_full) model_q.push_back(wd);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset.empty", {15'b0, empty}, 16'h1);
    check("reset.full", {15'b0, full}, 16'h0);
    check("reset.rd_data", rd_data, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic order
    for (int i = 0; i < 4; i++) step(1'b1, 16'(100 + i), 1'b0);
    check_model("basic.loaded");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("basic.head", rd_data, 16'(100 + i));
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);
    end
    check("basic.empty", {15'b0, empty}, 16'h1);
    check("basic.rd_data0", rd_data, 16'h0);

    // Full / overflow
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 16'(i), 1'b0);
      if (i == 7) check("ovf.full_after8", {15'b0, full}, 16'h1);
    end
    check_model("ovf.after9");
    for (int i = 0; i < 8; i++) begin
      check("ovf.read_order", rd_data, 16'(i));
      step(1'b0, 16'h0, 1'b1);
    end
    check("ovf.empty", {15'b0, empty}, 16'h1);

    // Underflow
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b1);
      check_model("udf.read_empty");
    end
    step(1'b1, 16'h55AA, 1'b0);
    check("udf.first_word", rd_data, 16'h55AA);
    step(1'b0, 16'h0, 1'b1);
    check_model("udf.drained");

    // Simultaneous push/pop with pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h200 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("sim.head", rd_data, 16'(16'h200 + i));
      step(1'b1, 16'(16'h203 + i), 1'b1);
      check("sim.occupancy", 16'(model_q.size()), 16'd3);
      check_model("sim.flags");
    end
    while (model_q.size() != 0) step(1'b0, 16'h0, 1'b1);
    check_model("sim.drained");

    // Full with both enables
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h300 + i), 1'b0);
    check("fullboth.full_before", {15'b0, full}, 16'h1);
    step(1'b1, 16'hDEAD, 1'b1);
    check("fullboth.full_after", {15'b0, full}, 16'h0);
    check("fullboth.head", rd_data, 16'h301);
    check_model("fullboth.model");

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.empty", {15'b0, empty}, 16'h1);
    check("arst.full", {15'b0, full}, 16'h0);
    check("arst.rd_data", rd_data, 16'h0);
    #1 rst = 1'b0;
    model_q.delete();
    check_model("arst.model");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
